// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- shared types for the pipeline control slice.
//   ctrl_state_t : hazard/stall FSM states (RUN, MEM_WAIT, HALT)
//   fwd_sel_t    : EX operand source select (FWD_RF, FWD_MEM, FWD_WB)
//   pipe_ctrl_t  : bundle of pipeline register load enables and flushes
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b01;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Uniform control word: every enable = en, every flush = fl.
  function automatic pipe_ctrl_t ctrl_fill(input logic en, input logic fl);
    pipe_ctrl_t c;
    c.pc_en       = en;
    c.if_id_en    = en;
    c.id_ex_en    = en;
    c.ex_mem_en   = en;
    c.mem_wb_en   = en;
    c.if_id_flush = fl;
    c.id_ex_flush = fl;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_fwd_unit.sv
// pipeline_fwd_unit -- combinational operand forwarding select.
// Ports:
//   rs1, rs2                     in  5  source registers
//   mem_w_addr, mem_reg_write    in  5/1 destination of the instruction in MEM
//   wb_w_addr, wb_reg_write      in  5/1 destination of the instruction in WB
//   fwd_a, fwd_b                 out 2  operand source (FWD_RF/FWD_MEM/FWD_WB)
module pipeline_fwd_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] mem_w_addr,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_w_addr,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // The younger producer (EX/MEM) wins; x0 is hard-wired zero and never forwarded.
  function automatic fwd_sel_t pick(input logic [4:0] rs,
                                    input logic [4:0] m_addr, input logic m_we,
                                    input logic [4:0] w_addr, input logic w_we);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (m_we && (m_addr == rs))      sel = FWD_MEM;
      else if (w_we && (w_addr == rs)) sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = pick(rs1, mem_w_addr, mem_reg_write, wb_w_addr, wb_reg_write);
    fwd_b = pick(rs2, mem_w_addr, mem_reg_write, wb_w_addr, wb_reg_write);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- 5-stage pipeline hazard, stall and forwarding control.
// Parameter MEM_TIMEOUT: max MEM_WAIT cycles before the sticky mem_err.
// Ports:
//   clk, rst (sync, active-high)
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2     ID-stage sources
//   ex_w_addr, ex_reg_write, ex_mem_read     EX-stage destination/control
//   mem_w_addr, mem_reg_write                MEM-stage destination
//   wb_w_addr, wb_reg_write                  WB-stage destination
//   ex_redirect                              taken branch / jump resolved in EX
//   mem_req, mem_ready                       data memory handshake
//   pc_en..mem_wb_en, if_id_flush/id_ex_flush  pipeline register control
//   fwd_a, fwd_b                             EX operand select
//   mem_err                                  sticky memory timeout
//   state                                    FSM state (debug)
// Optional: define PIPE_CTRL_PERF_EN to add saturating performance counters
//   stall_cycles, flush_count, loaduse_count (32 bits each).
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_w_addr,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_w_addr,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_w_addr,
  input  logic       wb_reg_write,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_err,
  output logic [1:0] state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] loaduse_count
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  pipe_ctrl_t       ctrl;
  logic             mem_stall, load_use, redirect_act, loaduse_act;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  // Only loads in EX create a hazard; the EX write enable itself is not needed here.
  logic ex_reg_write_unused;
  assign ex_reg_write_unused = ex_reg_write;

  pipeline_fwd_unit u_fwd (
    .rs1           (id_rs1),
    .rs2           (id_rs2),
    .mem_w_addr    (mem_w_addr),
    .mem_reg_write (mem_reg_write),
    .wb_w_addr     (wb_w_addr),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    mem_stall = 1'b0;

    load_use = ex_mem_read && (ex_w_addr != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_w_addr)) ||
                (id_use_rs2 && (id_rs2 == ex_w_addr)));

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          cnt_d     = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          mem_stall = 1'b1;
          if (cnt_q >= CNT_MAX) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HALT:    mem_stall = 1'b1;
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    // A frozen EX cannot act on its redirect; it is honoured when the stall releases.
    redirect_act = !rst && !mem_stall && ex_redirect;
    loaduse_act  = !rst && !mem_stall && !ex_redirect && load_use;

    ctrl = ctrl_fill(1'b1, 1'b0);
    if (mem_stall) begin
      ctrl = ctrl_fill(1'b0, 1'b0);
    end else if (ex_redirect) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX; the load moves on.
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
    if (rst) ctrl = ctrl_fill(1'b0, 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign fwd_a       = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b       = rst ? FWD_RF : fwd_b_raw;
  assign mem_err     = mem_err_q;
  assign state       = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d, flush_q, flush_d, lu_q, lu_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    stall_d = sat_inc(stall_q, state_q != RUN);
    flush_d = sat_inc(flush_q, redirect_act);
    lu_d    = sat_inc(lu_q, loaduse_act);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      lu_q    <= lu_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign loaduse_count = lu_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255; the maximum MEM_WAIT cycles before the block declares a memory error.
REQ-002 Port: clk, in, 1; the single clock; all state updates on its rising edge.
REQ-003 Port: rst, in, 1; reset, synchronous, active-high.
REQ-004 Port: id_rs1, id_rs2, in, 5 each; source registers of the instruction in ID.
REQ-005 Port: id_use_rs1, id_use_rs2, in, 1 each; ID instruction actually reads rs1/rs2.
REQ-006 Port: ex_w_addr, ex_reg_write, ex_mem_read, in, 5/1/1; destination register and control bits of the instruction in EX.
REQ-007 Port: mem_w_addr, mem_reg_write, in, 5/1; destination register and write enable of the instruction in MEM.
REQ-008 Port: wb_w_addr, wb_reg_write, in, 5/1; destination register and write enable of the instruction in WB.
REQ-009 Port: ex_redirect, in, 1; the branch is taken or a jal/jalr is resolved in EX.
REQ-010 Port: mem_req, mem_ready, in, 1 each; MEM-stage data access request and data-memory acknowledge.
REQ-011 Port: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, out, 1 each; per-register load enables.
REQ-012 Port: if_id_flush, id_ex_flush, out, 1 each; load a bubble (all control bits 0) into the named register.
REQ-013 Port: fwd_a, fwd_b, out, 2 each; EX operand source: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-014 Port: mem_err, out, 1; sticky memory-timeout error.
REQ-015 Port: state, out, 2; current FSM state, for debug.

Function
REQ-016 The FSM SHALL have three states: RUN=0, MEM_WAIT=1, HALT=2.
REQ-017 In RUN with no hazard, all five enables SHALL be 1 and both flushes SHALL be 0.
REQ-018 mem_req && !mem_ready in RUN: all enables SHALL be 0 in that cycle, and the FSM SHALL go to MEM_WAIT with the wait counter = 1.
REQ-019 In MEM_WAIT: all enables SHALL be 0 and the counter SHALL increment each cycle.
REQ-020 When mem_ready=1 in MEM_WAIT: all enables SHALL be 1 that cycle and the next state SHALL be RUN.
REQ-021 When the counter reaches MEM_TIMEOUT with mem_ready=0: next state SHALL be HALT and mem_err SHALL be set.
REQ-022 HALT SHALL hold all enables at 0 until rst; only rst leaves HALT.
REQ-023 Load-use hazard: ex_mem_read && ex_w_addr!=0 && ex_w_addr equals a used ID source register.
REQ-024 On a load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1; this gives a one-cycle bubble.
REQ-025 ex_redirect=1 in RUN SHALL assert if_id_flush=1 and id_ex_flush=1 in the same cycle, with pc_en=1.
REQ-026 Priority SHALL be memory stall > redirect > load-use.
REQ-027 A redirect during MEM_WAIT SHALL NOT be acted on; it is acted on the cycle the stall releases, since EX is frozen.
REQ-028 Forwarding: EX/MEM SHALL win over MEM/WB; there is no forwarding from register x0; a source matches only when the corresponding reg_write=1.
REQ-029 Forwarding selects SHALL be combinational, zero latency.
REQ-030 The wait counter SHALL be $clog2(MEM_TIMEOUT+1) bits and SHALL NOT wrap.

Reset
REQ-031 While rst=1: all enables SHALL be 0, both flushes 1, and fwd_a/fwd_b 00.
REQ-032 On the first clock with rst=1: state SHALL become RUN, the counter 0, mem_err 0, and performance counters 0.
REQ-033 rst asserted mid-MEM_WAIT or in HALT SHALL abort the wait with no residual state.

Configuration
REQ-034 With PIPE_CTRL_PERF_EN defined: the block SHALL add outputs stall_cycles[31:0], flush_count[31:0] and loaduse_count[31:0]; they saturate at 0xFFFFFFFF.
REQ-035 Counting rules: stall_cycles counts cycles in MEM_WAIT or HALT; flush_count counts acted-on redirects; loaduse_count counts load-use bubbles.
REQ-036 Without PIPE_CTRL_PERF_EN: these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-037 pipeline_pkg SHALL gain: ctrl_state_t enum (RUN, MEM_WAIT, HALT); fwd_sel_t constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01; and a pipe_ctrl_t struct bundling the enables and flushes.
REQ-038 Forwarding SHALL be the sub-module pipeline_fwd_unit, purely combinational; the FSM and hazard logic SHALL stay in pipeline_ctrl.

Verification
REQ-039 Load-use: ex_mem_read=1, ex_w_addr=5, id_rs1=5, id_use_rs1=1 -> for one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1.
REQ-040 Double forward: mem_w_addr=7 and wb_w_addr=7, both reg_write=1, id_rs2=7 -> fwd_b=10; with mem_w_addr=0 instead -> fwd_b=01; with id_rs2=0 -> fwd_b=00.
REQ-041 Memory wait: mem_req=1, mem_ready held 0 for 3 cycles then 1 -> all enables 0 for 3 cycles, state=1, then enables 1 and state=0.
REQ-042 Timeout: MEM_TIMEOUT=4, mem_ready never asserted -> state=2 and mem_err=1 after 4 wait cycles; mem_err stays 1 until rst; after rst, state=0.
REQ-043 Redirect in stall: ex_redirect=1 during MEM_WAIT -> no flush; the cycle mem_ready=1 -> if_id_flush=1 and id_ex_flush=1.
REQ-044 Reset mid-wait: rst pulsed in cycle 2 of MEM_WAIT -> next cycle state=0 and counter=0; with PIPE_CTRL_PERF_EN defined, stall_cycles=0.
